jtag_cmd_mailbox: RTL and testbench

Command mailbox that turns the flat host-written JTAG registers into single, handshaked bus transactions on the FPGA fabric. It consumes two host→FPGA registers from the JTAG register bank (command word and write data) and produces two FPGA→host registers (status word and read data). A toggle-bit protocol and an input-stability filter ensure that each host command executes exactly once, even though the host writes multi-bit registers non-atomically.

---
 rtl/jtag_cmd_mailbox.sv | 153 +++++++++++++++
 tb/tb_jtag_cmd_mailbox.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_cmd_mailbox.sv
// Command mailbox: converts host-written JTAG command/data registers into exactly
// one handshaked fabric transaction per flip of the request toggle bit.
module jtag_cmd_mailbox #(
  parameter int WIDTH          = 32,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             iMAIN_CLK,
  input  logic             iRESET,
  input  logic [WIDTH-1:0] iCMD,
  input  logic [WIDTH-1:0] iWDATA,
  output logic [WIDTH-1:0] oSTATUS,
  output logic [WIDTH-1:0] oRDATA,
  output logic             oBUS_VALID,
  input  logic             iBUS_READY,
  output logic             oBUS_WRITE,
  output logic [15:0]      oBUS_ADDR,
  output logic [WIDTH-1:0] oBUS_WDATA,
  input  logic [WIDTH-1:0] iBUS_RDATA
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_ISSUE, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_samp_cmd;
  logic [WIDTH-1:0] r_samp_wdata;
  logic [SW-1:0]    r_stab_cnt;
  logic [TW-1:0]    r_to_cnt;
  logic             r_ack;
  logic             r_tog;
  logic             r_err;
  logic [15:0]      r_count;
  logic [WIDTH-1:0] r_rdata;
  logic             r_bus_write;
  logic [15:0]      r_bus_addr;
  logic [WIDTH-1:0] r_bus_wdata;

  logic             w_pending;
  logic             w_stable;
  logic             w_issue;
  logic             w_hs;
  logic             w_tmo;
  logic [WIDTH-1:0] w_status;

  assign w_pending = (iCMD[WIDTH-1] != r_ack);
  assign w_stable  = (iCMD == r_samp_cmd) && (iWDATA == r_samp_wdata);

  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    w_hs    = 1'b0;
    w_tmo   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pending) w_next = S_SETTLE;
      end
      S_SETTLE: begin
        if (!w_pending) begin
          w_next = S_IDLE;
        end else if (w_stable && (r_stab_cnt == STAB_LAST)) begin
          w_issue = 1'b1;
          w_next  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (iBUS_READY) begin
          w_hs   = 1'b1;
          w_next = S_DONE;
        end else if (r_to_cnt == TO_LAST) begin
          w_tmo  = 1'b1;
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iMAIN_CLK) begin
    if (iRESET) begin
      r_state      <= S_IDLE;
      r_samp_cmd   <= '0;
      r_samp_wdata <= '0;
      r_stab_cnt   <= '0;
      r_to_cnt     <= '0;
      r_ack        <= 1'b0;
      r_tog        <= 1'b0;
      r_err        <= 1'b0;
      r_count      <= '0;
      r_rdata      <= '0;
      r_bus_write  <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_wdata  <= '0;
    end else begin
      r_state      <= w_next;
      r_samp_cmd   <= iCMD;
      r_samp_wdata <= iWDATA;
      case (r_state)
        S_IDLE: r_stab_cnt <= '0;
        S_SETTLE: begin
          if (!w_stable) r_stab_cnt <= '0;
          else if (!w_issue) r_stab_cnt <= r_stab_cnt + 1'b1;
          // Transaction fields are frozen here; later host writes cannot disturb it.
          if (w_issue) begin
            r_tog       <= iCMD[WIDTH-1];
            r_bus_write <= iCMD[WIDTH-2];
            r_bus_addr  <= iCMD[15:0];
            r_bus_wdata <= iWDATA;
            r_to_cnt    <= '0;
          end
        end
        S_ISSUE: begin
          if (w_hs) begin
            if (!r_bus_write) r_rdata <= iBUS_RDATA;
            r_err <= 1'b0;
          end else if (w_tmo) begin
            r_rdata <= '1;
            r_err   <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_ack   <= r_tog;
          r_count <= r_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_status          = '0;
    w_status[WIDTH-1] = r_ack;
    w_status[WIDTH-2] = (r_state != S_IDLE);
    w_status[WIDTH-3] = r_err;
    w_status[15:0]    = r_count;
  end

  assign oSTATUS    = w_status;
  assign oRDATA     = r_rdata;
  assign oBUS_VALID = (r_state == S_ISSUE);
  assign oBUS_WRITE = r_bus_write;
  assign oBUS_ADDR  = r_bus_addr;
  assign oBUS_WDATA = r_bus_wdata;

endmodule

// File: tb/tb_jtag_cmd_mailbox.sv
// Bench for jtag_cmd_mailbox: scenario tasks with a queue of expected bus requests.
module tb_jtag_cmd_mailbox;

  logic        clk = 1'b0;
  logic        iRESET = 1'b1;
  logic [31:0] iCMD = '0;
  logic [31:0] iWDATA = '0;
  logic [31:0] oSTATUS;
  logic [31:0] oRDATA;
  logic        oBUS_VALID;
  logic        iBUS_READY = 1'b0;
  logic        oBUS_WRITE;
  logic [15:0] oBUS_ADDR;
  logic [31:0] oBUS_WDATA;
  logic [31:0] iBUS_RDATA = '0;

  int checks = 0;
  int errors = 0;
  int n_req = 0;
  logic v_prev = 1'b0;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wd;
  } req_t;
  req_t sb_q[$];

  jtag_cmd_mailbox #(.WIDTH(32), .STABLE_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
    .iMAIN_CLK(clk), .iRESET(iRESET), .iCMD(iCMD), .iWDATA(iWDATA),
    .oSTATUS(oSTATUS), .oRDATA(oRDATA), .oBUS_VALID(oBUS_VALID),
    .iBUS_READY(iBUS_READY), .oBUS_WRITE(oBUS_WRITE), .oBUS_ADDR(oBUS_ADDR),
    .oBUS_WDATA(oBUS_WDATA), .iBUS_RDATA(iBUS_RDATA)
  );

  always #5 clk = ~clk;

  // Each rising edge of oBUS_VALID is one request.
  always @(posedge clk) begin
    if (oBUS_VALID && !v_prev) n_req <= n_req + 1;
    v_prev <= oBUS_VALID;
  end

  task automatic test_reset();
    int bad;
    repeat (3) @(negedge clk);
    iRESET = 1'b0;
    @(negedge clk);
    checks++;
    if (oSTATUS !== 32'h0) begin errors++; $display("FAIL reset_status: got %h expected %h", oSTATUS, 32'h0); end
    checks++;
    if ({oBUS_VALID, oBUS_WRITE, oBUS_ADDR, oBUS_WDATA, oRDATA} !== 82'h0)
      begin errors++; $display("FAIL reset_outputs: got valid=%b wr=%b addr=%h wd=%h rd=%h expected all 0", oBUS_VALID, oBUS_WRITE, oBUS_ADDR, oBUS_WDATA, oRDATA); end
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (oBUS_VALID !== 1'b0 || oSTATUS !== 32'h0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL idle_quiet: got %0d active cycles expected 0", bad); end
    checks++;
    if (n_req != 0) begin errors++; $display("FAIL idle_requests: got %0d expected 0", n_req); end
  endtask

  task automatic test_read();
    req_t e, got;
    bit ok;
    int n0;
    n0 = n_req;
    iCMD = 32'h8000_0012;
    e = {1'b0, 16'h0012, 32'h0};
    sb_q.push_back(e);
    ok = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k < 5 && oBUS_VALID !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok || oBUS_VALID !== 1'b1) begin errors++; $display("FAIL read_latency: got valid=%b early=%b expected rise at cycle 5", oBUS_VALID, !ok); end
    got = {oBUS_WRITE, oBUS_ADDR, oBUS_WDATA};
    checks++;
    if (sb_q.size() == 0) begin errors++; $display("FAIL read_sb: got empty queue expected entry"); end
    else begin
      e = sb_q.pop_front();
      if (got !== e) begin errors++; $display("FAIL read_req: got %h expected %h", got, e); end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (oBUS_VALID !== 1'b1 || oBUS_ADDR !== 16'h0012) begin errors++; $display("FAIL read_hold: got valid=%b addr=%h expected 1 0012", oBUS_VALID, oBUS_ADDR); end
    iBUS_READY = 1'b1;
    iBUS_RDATA = 32'hCAFE_F00D;
    @(negedge clk);
    iBUS_READY = 1'b0;
    checks++;
    if (oBUS_VALID !== 1'b0 || oRDATA !== 32'hCAFE_F00D || oSTATUS !== 32'h4000_0000)
      begin errors++; $display("FAIL read_done: got valid=%b rdata=%h status=%h expected 0 cafef00d 40000000", oBUS_VALID, oRDATA, oSTATUS); end
    @(negedge clk);
    checks++;
    if (oSTATUS !== 32'h8000_0001) begin errors++; $display("FAIL read_status: got %h expected %h", oSTATUS, 32'h8000_0001); end
    checks++;
    if (n_req - n0 != 1) begin errors++; $display("FAIL read_count: got %0d requests expected 1", n_req - n0); end
  endtask

  task automatic test_write();
    req_t e, got;
    bit found;
    int n0;
    n0 = n_req;
    iWDATA = 32'h1234_5678;
    iCMD = 32'h4000_00A5;
    iBUS_READY = 1'b1;
    e = {1'b1, 16'h00A5, 32'h1234_5678};
    sb_q.push_back(e);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (oBUS_VALID === 1'b1) found = 1'b1;
    end
    got = {oBUS_WRITE, oBUS_ADDR, oBUS_WDATA};
    checks++;
    if (!found || sb_q.size() == 0) begin errors++; $display("FAIL write_wait: got valid=%b expected 1 within 20 cycles", oBUS_VALID); end
    else begin
      e = sb_q.pop_front();
      if (got !== e) begin errors++; $display("FAIL write_req: got %h expected %h", got, e); end
    end
    @(negedge clk);
    iBUS_READY = 1'b0;
    checks++;
    if (oBUS_VALID !== 1'b0) begin errors++; $display("FAIL write_single: got valid=%b expected 0", oBUS_VALID); end
    @(negedge clk);
    checks++;
    if (oSTATUS !== 32'h0000_0002 || oRDATA !== 32'hCAFE_F00D)
      begin errors++; $display("FAIL write_status: got status=%h rdata=%h expected 00000002 cafef00d", oSTATUS, oRDATA); end
    repeat (5) @(negedge clk);
    checks++;
    if (n_req - n0 != 1) begin errors++; $display("FAIL write_count: got %0d requests expected 1", n_req - n0); end
  endtask

  task automatic test_torn();
    req_t e, got;
    bit ok;
    int bad, n0;
    n0 = n_req;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      iCMD = 32'h8000_0030 + 32'(i);
      iWDATA = 32'(i);
      repeat (2) begin
        @(negedge clk);
        if (oBUS_VALID !== 1'b0) bad++;
      end
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL torn_quiet: got %0d valid cycles expected 0", bad); end
    iCMD = 32'h8000_0077;
    iWDATA = 32'hDEAD_0001;
    e = {1'b0, 16'h0077, 32'hDEAD_0001};
    sb_q.push_back(e);
    ok = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k < 5 && oBUS_VALID !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok || oBUS_VALID !== 1'b1) begin errors++; $display("FAIL torn_latency: got valid=%b early=%b expected rise at cycle 5", oBUS_VALID, !ok); end
    got = {oBUS_WRITE, oBUS_ADDR, oBUS_WDATA};
    checks++;
    if (sb_q.size() == 0) begin errors++; $display("FAIL torn_sb: got empty queue expected entry"); end
    else begin
      e = sb_q.pop_front();
      if (got !== e) begin errors++; $display("FAIL torn_req: got %h expected %h", got, e); end
    end
    iBUS_READY = 1'b1;
    iBUS_RDATA = 32'h0BAD_BEEF;
    @(negedge clk);
    iBUS_READY = 1'b0;
    @(negedge clk);
    checks++;
    if (oSTATUS !== 32'h8000_0003 || oRDATA !== 32'h0BAD_BEEF)
      begin errors++; $display("FAIL torn_status: got status=%h rdata=%h expected 80000003 0badbeef", oSTATUS, oRDATA); end
    checks++;
    if (n_req - n0 != 1) begin errors++; $display("FAIL torn_count: got %0d requests expected 1", n_req - n0); end
  endtask

  task automatic test_timeout();
    req_t e, got;
    bit ok, found;
    int n_hi;
    iCMD = 32'h0000_0099;
    iWDATA = 32'h0;
    e = {1'b0, 16'h0099, 32'h0};
    sb_q.push_back(e);
    ok = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k < 5 && oBUS_VALID !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok || oBUS_VALID !== 1'b1) begin errors++; $display("FAIL tmo_latency: got valid=%b early=%b expected rise at cycle 5", oBUS_VALID, !ok); end
    got = {oBUS_WRITE, oBUS_ADDR, oBUS_WDATA};
    checks++;
    if (sb_q.size() == 0) begin errors++; $display("FAIL tmo_sb: got empty queue expected entry"); end
    else begin
      e = sb_q.pop_front();
      if (got !== e) begin errors++; $display("FAIL tmo_req: got %h expected %h", got, e); end
    end
    n_hi = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (oBUS_VALID !== 1'b1) break;
      n_hi++;
    end
    checks++;
    if (n_hi != 16) begin errors++; $display("FAIL tmo_len: got %0d valid cycles expected 16", n_hi); end
    checks++;
    if (oRDATA !== 32'hFFFF_FFFF || oSTATUS[29] !== 1'b1)
      begin errors++; $display("FAIL tmo_err: got rdata=%h err=%b expected ffffffff 1", oRDATA, oSTATUS[29]); end
    @(negedge clk);
    checks++;
    if (oSTATUS !== 32'h2000_0004) begin errors++; $display("FAIL tmo_status: got %h expected %h", oSTATUS, 32'h2000_0004); end
    iCMD = 32'h8000_0100;
    iBUS_READY = 1'b1;
    iBUS_RDATA = 32'h5555_AAAA;
    e = {1'b0, 16'h0100, 32'h0};
    sb_q.push_back(e);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (oBUS_VALID === 1'b1) found = 1'b1;
    end
    got = {oBUS_WRITE, oBUS_ADDR, oBUS_WDATA};
    checks++;
    if (!found || sb_q.size() == 0) begin errors++; $display("FAIL recover_wait: got valid=%b expected 1 within 20 cycles", oBUS_VALID); end
    else begin
      e = sb_q.pop_front();
      if (got !== e) begin errors++; $display("FAIL recover_req: got %h expected %h", got, e); end
    end
    @(negedge clk);
    iBUS_READY = 1'b0;
    @(negedge clk);
    checks++;
    if (oSTATUS !== 32'h8000_0005 || oRDATA !== 32'h5555_AAAA)
      begin errors++; $display("FAIL recover_status: got status=%h rdata=%h expected 80000005 5555aaaa", oSTATUS, oRDATA); end
  endtask

  task automatic test_withdraw_reset();
    req_t e, got;
    bit found;
    int bad, n0;
    n0 = n_req;
    iCMD = 32'h0000_0100;
    repeat (2) @(negedge clk);
    iCMD = 32'h8000_0100;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (oBUS_VALID !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || n_req != n0) begin errors++; $display("FAIL withdraw_quiet: got %0d valid cycles %0d requests expected 0 0", bad, n_req - n0); end
    checks++;
    if (oSTATUS !== 32'h8000_0005) begin errors++; $display("FAIL withdraw_status: got %h expected %h", oSTATUS, 32'h8000_0005); end
    iCMD = 32'h0000_0200;
    e = {1'b0, 16'h0200, 32'h0};
    sb_q.push_back(e);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (oBUS_VALID === 1'b1) found = 1'b1;
    end
    got = {oBUS_WRITE, oBUS_ADDR, oBUS_WDATA};
    checks++;
    if (!found || sb_q.size() == 0) begin errors++; $display("FAIL rst_wait: got valid=%b expected 1 within 20 cycles", oBUS_VALID); end
    else begin
      e = sb_q.pop_front();
      if (got !== e) begin errors++; $display("FAIL rst_req: got %h expected %h", got, e); end
    end
    @(negedge clk);
    iRESET = 1'b1;
    @(negedge clk);
    checks++;
    if (oBUS_VALID !== 1'b0 || oSTATUS !== 32'h0 || oRDATA !== 32'h0)
      begin errors++; $display("FAIL rst_mid: got valid=%b status=%h rdata=%h expected 0 0 0", oBUS_VALID, oSTATUS, oRDATA); end
    iRESET = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (oSTATUS !== 32'h0 || oBUS_VALID !== 1'b0) begin errors++; $display("FAIL rst_after: got status=%h valid=%b expected 0 0", oSTATUS, oBUS_VALID); end
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size()); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_torn();
    test_timeout();
    test_withdraw_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
